// File: rtl/sc_ir_pkg.sv
// Shared definitions for the SPARC-format instruction register queue:
// field positions inside the 32-bit instruction word and the OP-class encodings.
package sc_ir_pkg;

  localparam int OP_HI     = 31;
  localparam int OP_LO     = 30;
  localparam int RD_HI     = 29;
  localparam int RD_LO     = 25;
  localparam int OP2_HI    = 24;
  localparam int OP2_LO    = 22;
  localparam int OP3_HI    = 24;
  localparam int OP3_LO    = 19;
  localparam int RS1_HI    = 18;
  localparam int RS1_LO    = 14;
  localparam int BIT13     = 13;
  localparam int RS2_HI    = 4;
  localparam int RS2_LO    = 0;
  localparam int SIMM13_HI = 12;
  localparam int DISP22_HI = 21;
  localparam int DISP30_HI = 29;

  typedef enum logic [1:0] {
    OP_BRANCH = 2'b00,  // branches and SETHI
    OP_CALL   = 2'b01,
    OP_ARITH  = 2'b10,
    OP_MEM    = 2'b11
  } op_e;

  // Whether the IR currently carries an instruction or a bubble.
  typedef enum logic {
    IR_BUBBLE = 1'b0,
    IR_LIVE   = 1'b1
  } ir_state_e;

endpackage

// File: rtl/sc_reg_ir_queue_if.sv
// Bus between the fetch/control side (master) and the instruction queue (slave):
// push/advance/flush requests in, IR word, decoded fields and queue status out.
interface sc_reg_ir_queue_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DEPTH         = 4,
  parameter int CNT_W         = $clog2(DEPTH) + 1
);

  logic                     SC_RegIRQ_Write_InHigh;
  logic [DATAWIDTH_BUS-1:0] SC_RegIRQ_DataBUS_In;
  logic                     SC_RegIRQ_Next_InHigh;
  logic                     SC_RegIRQ_Flush_InHigh;

  logic [DATAWIDTH_BUS-1:0] SC_RegIRQ_DataBUS_Out;
  logic                     SC_RegIRQ_Valid;
  logic                     SC_RegIRQ_Full;
  logic                     SC_RegIRQ_Empty;
  logic [CNT_W-1:0]         SC_RegIRQ_Count;
  logic [1:0]               SC_RegIRQ_OP;
  logic [4:0]               SC_RegIRQ_RD;
  logic [2:0]               SC_RegIRQ_OP2;
  logic [5:0]               SC_RegIRQ_OP3;
  logic [4:0]               SC_RegIRQ_RS1;
  logic                     SC_RegIRQ_BIT13;
  logic [4:0]               SC_RegIRQ_RS2;
  logic [DATAWIDTH_BUS-1:0] SC_RegIRQ_SIMM13;
  logic [DATAWIDTH_BUS-1:0] SC_RegIRQ_DISP22;
  logic [DATAWIDTH_BUS-1:0] SC_RegIRQ_DISP30;

  modport master (
    output SC_RegIRQ_Write_InHigh, SC_RegIRQ_DataBUS_In,
           SC_RegIRQ_Next_InHigh, SC_RegIRQ_Flush_InHigh,
    input  SC_RegIRQ_DataBUS_Out, SC_RegIRQ_Valid, SC_RegIRQ_Full,
           SC_RegIRQ_Empty, SC_RegIRQ_Count, SC_RegIRQ_OP, SC_RegIRQ_RD,
           SC_RegIRQ_OP2, SC_RegIRQ_OP3, SC_RegIRQ_RS1, SC_RegIRQ_BIT13,
           SC_RegIRQ_RS2, SC_RegIRQ_SIMM13, SC_RegIRQ_DISP22, SC_RegIRQ_DISP30
  );

  modport slave (
    input  SC_RegIRQ_Write_InHigh, SC_RegIRQ_DataBUS_In,
           SC_RegIRQ_Next_InHigh, SC_RegIRQ_Flush_InHigh,
    output SC_RegIRQ_DataBUS_Out, SC_RegIRQ_Valid, SC_RegIRQ_Full,
           SC_RegIRQ_Empty, SC_RegIRQ_Count, SC_RegIRQ_OP, SC_RegIRQ_RD,
           SC_RegIRQ_OP2, SC_RegIRQ_OP3, SC_RegIRQ_RS1, SC_RegIRQ_BIT13,
           SC_RegIRQ_RS2, SC_RegIRQ_SIMM13, SC_RegIRQ_DISP22, SC_RegIRQ_DISP30
  );

endinterface

// File: rtl/sc_ir_fifo.sv
// DEPTH-entry prefetch queue: circular storage with wrapping pointers, occupancy
// count and flush. State changes on the falling clock edge.
module sc_ir_fifo #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DEPTH         = 4,
  parameter int CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATAWIDTH_BUS-1:0] wr_data,
  output logic [DATAWIDTH_BUS-1:0] rd_data,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATAWIDTH_BUS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic                     push_ok;
  logic                     pop_ok;

  // Status comes from the registered count only, so requests never see themselves.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural overflow gives the modulo wrap.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; a slot is only ever read
  // after being written, and leaving it out of reset keeps it a plain RAM.
  always_ff @(negedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sc_reg_ir_queue.sv
// Instruction register fed by a prefetch queue: owns the IR word, its live/bubble
// state and the combinational SPARC field and immediate decode.
module sc_reg_ir_queue
  import sc_ir_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DEPTH         = 4,
  parameter int CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic               SC_RegIRQ_CLOCK_50,
  input  logic               SC_RegIRQ_Reset_InLow,
  sc_reg_ir_queue_if.slave   bus
);

  logic [DATAWIDTH_BUS-1:0] ir;
  ir_state_e                ir_state;
  logic [DATAWIDTH_BUS-1:0] head;
  logic                     q_empty;

  sc_ir_fifo #(
    .DATAWIDTH_BUS (DATAWIDTH_BUS),
    .DEPTH         (DEPTH),
    .CNT_W         (CNT_W)
  ) u_fifo (
    .clk     (SC_RegIRQ_CLOCK_50),
    .rst_n   (SC_RegIRQ_Reset_InLow),
    .flush   (bus.SC_RegIRQ_Flush_InHigh),
    .push    (bus.SC_RegIRQ_Write_InHigh),
    .pop     (bus.SC_RegIRQ_Next_InHigh),
    .wr_data (bus.SC_RegIRQ_DataBUS_In),
    .rd_data (head),
    .count   (bus.SC_RegIRQ_Count),
    .full    (bus.SC_RegIRQ_Full),
    .empty   (q_empty)
  );

  assign bus.SC_RegIRQ_Empty = q_empty;

  // A Next on an empty queue yields a bubble; the old word stays visible.
  always_ff @(negedge SC_RegIRQ_CLOCK_50 or negedge SC_RegIRQ_Reset_InLow) begin
    if (!SC_RegIRQ_Reset_InLow) begin
      ir       <= '0;
      ir_state <= IR_BUBBLE;
    end else if (bus.SC_RegIRQ_Flush_InHigh) begin
      ir       <= '0;
      ir_state <= IR_BUBBLE;
    end else if (bus.SC_RegIRQ_Next_InHigh) begin
      if (!q_empty) begin
        ir       <= head;
        ir_state <= IR_LIVE;
      end else begin
        ir_state <= IR_BUBBLE;
      end
    end
  end

  assign bus.SC_RegIRQ_DataBUS_Out = ir;
  assign bus.SC_RegIRQ_Valid       = (ir_state == IR_LIVE);

  assign bus.SC_RegIRQ_OP    = ir[OP_HI:OP_LO];
  assign bus.SC_RegIRQ_RD    = ir[RD_HI:RD_LO];
  assign bus.SC_RegIRQ_OP2   = ir[OP2_HI:OP2_LO];
  assign bus.SC_RegIRQ_OP3   = ir[OP3_HI:OP3_LO];
  assign bus.SC_RegIRQ_RS1   = ir[RS1_HI:RS1_LO];
  assign bus.SC_RegIRQ_BIT13 = ir[BIT13];
  assign bus.SC_RegIRQ_RS2   = ir[RS2_HI:RS2_LO];

  assign bus.SC_RegIRQ_SIMM13 = {{(DATAWIDTH_BUS-SIMM13_HI-1){ir[SIMM13_HI]}}, ir[SIMM13_HI:0]};
  assign bus.SC_RegIRQ_DISP22 = {{(DATAWIDTH_BUS-DISP22_HI-1){ir[DISP22_HI]}}, ir[DISP22_HI:0]};
  assign bus.SC_RegIRQ_DISP30 = {{(DATAWIDTH_BUS-DISP30_HI-1){ir[DISP30_HI]}}, ir[DISP30_HI:0]};

endmodule

// File: tb/tb_sc_reg_ir_queue.sv
// Bench for sc_reg_ir_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the IR queue.
module tb_sc_reg_ir_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;

  sc_reg_ir_queue_if #(.DATAWIDTH_BUS(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  sc_reg_ir_queue #(.DATAWIDTH_BUS(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .SC_RegIRQ_CLOCK_50    (clk),
    .SC_RegIRQ_Reset_InLow (rst_n),
    .bus                   (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: the queue contents, IR word and IR liveness.
  logic [W-1:0] m_q [$];
  logic [W-1:0] m_ir;
  logic         m_valid;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sext(input logic [W-1:0] raw, input int bits);
    logic [W-1:0] span;
    span = W'(1) << bits;
    if (raw[bits-1]) return raw - span;
    return raw;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ir    = '0;
    m_valid = 1'b0;
  endtask

  // Apply one edge of the spec rules to the model (status taken before the edge).
  task automatic model_step(input logic w, input logic [W-1:0] d, input logic n, input logic f);
    bit was_full;
    bit was_empty;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (f) begin
      model_reset();
    end else begin
      if (n) begin
        if (!was_empty) begin
          m_ir    = m_q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (w && !was_full) m_q.push_back(d);
    end
  endtask

  task automatic step(input logic w, input logic [W-1:0] d, input logic n, input logic f);
    bus.SC_RegIRQ_Write_InHigh = w;
    bus.SC_RegIRQ_DataBUS_In   = d;
    bus.SC_RegIRQ_Next_InHigh  = n;
    bus.SC_RegIRQ_Flush_InHigh = f;
    @(negedge clk);
    model_step(w, d, n, f);
    #2;
    bus.SC_RegIRQ_Write_InHigh = 1'b0;
    bus.SC_RegIRQ_Next_InHigh  = 1'b0;
    bus.SC_RegIRQ_Flush_InHigh = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] cnt;
    cnt = W'(m_q.size());
    check({tag, ".count"}, W'(bus.SC_RegIRQ_Count), cnt);
    check({tag, ".empty"}, W'(bus.SC_RegIRQ_Empty), W'(cnt == 0));
    check({tag, ".full"},  W'(bus.SC_RegIRQ_Full),  W'(cnt == DEPTH));
    check({tag, ".valid"}, W'(bus.SC_RegIRQ_Valid), W'(m_valid));
    check({tag, ".ir"},    bus.SC_RegIRQ_DataBUS_Out, m_ir);
    check({tag, ".op"},    W'(bus.SC_RegIRQ_OP),    m_ir / 32'h4000_0000);
    check({tag, ".rd"},    W'(bus.SC_RegIRQ_RD),    (m_ir >> 25) % 32);
    check({tag, ".op2"},   W'(bus.SC_RegIRQ_OP2),   (m_ir >> 22) % 8);
    check({tag, ".op3"},   W'(bus.SC_RegIRQ_OP3),   (m_ir >> 19) % 64);
    check({tag, ".rs1"},   W'(bus.SC_RegIRQ_RS1),   (m_ir >> 14) % 32);
    check({tag, ".bit13"}, W'(bus.SC_RegIRQ_BIT13), (m_ir >> 13) % 2);
    check({tag, ".rs2"},   W'(bus.SC_RegIRQ_RS2),   m_ir % 32);
    check({tag, ".simm13"}, bus.SC_RegIRQ_SIMM13, sext(m_ir % 32'h2000, 13));
    check({tag, ".disp22"}, bus.SC_RegIRQ_DISP22, sext(m_ir % 32'h40_0000, 22));
    check({tag, ".disp30"}, bus.SC_RegIRQ_DISP30, sext(m_ir % 32'h4000_0000, 30));
  endtask

  initial begin
    rst_n                      = 1'b0;
    bus.SC_RegIRQ_Write_InHigh = 1'b0;
    bus.SC_RegIRQ_DataBUS_In   = '0;
    bus.SC_RegIRQ_Next_InHigh  = 1'b0;
    bus.SC_RegIRQ_Flush_InHigh = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // 1: reset state
    check_all("reset");
    check("reset.ir_const", bus.SC_RegIRQ_DataBUS_Out, 32'h0);
    check("reset.empty_const", W'(bus.SC_RegIRQ_Empty), 32'd1);

    // 2: arithmetic-format decode
    step(1'b1, 32'h8A00_4002, 1'b0, 1'b0);
    check_all("arith.push");
    step(1'b0, '0, 1'b1, 1'b0);
    check_all("arith.next");
    check("arith.op",    W'(bus.SC_RegIRQ_OP),    32'd2);
    check("arith.rd",    W'(bus.SC_RegIRQ_RD),    32'd5);
    check("arith.op3",   W'(bus.SC_RegIRQ_OP3),   32'd0);
    check("arith.rs1",   W'(bus.SC_RegIRQ_RS1),   32'd1);
    check("arith.bit13", W'(bus.SC_RegIRQ_BIT13), 32'd0);
    check("arith.rs2",   W'(bus.SC_RegIRQ_RS2),   32'd2);
    check("arith.count", W'(bus.SC_RegIRQ_Count), 32'd0);

    // 3: negative simm13, then branch displacement
    step(1'b1, 32'h9A00_7FFF, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_all("simm");
    check("simm.bit13", W'(bus.SC_RegIRQ_BIT13), 32'd1);
    check("simm.value", bus.SC_RegIRQ_SIMM13, 32'hFFFF_FFFF);
    step(1'b1, 32'h1080_0003, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_all("branch");
    check("branch.op2",    W'(bus.SC_RegIRQ_OP2), 32'd2);
    check("branch.disp22", bus.SC_RegIRQ_DISP22,  32'h0000_0003);

    // 4: overfill, drain, bubble
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h11 + W'(i), 1'b0, 1'b0);
      check_all("fill");
      if (i == 3) check("fill.full_at4", W'(bus.SC_RegIRQ_Full), 32'd1);
    end
    check("fill.count_capped", W'(bus.SC_RegIRQ_Count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check_all("drain");
      check("drain.ir_order", bus.SC_RegIRQ_DataBUS_Out, 32'h11 + W'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check_all("bubble");
    check("bubble.valid", W'(bus.SC_RegIRQ_Valid), 32'd0);
    check("bubble.ir_hold", bus.SC_RegIRQ_DataBUS_Out, 32'h14);

    // 5: flush wins over a simultaneous push and next
    step(1'b1, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 1'b1, 1'b0);
    step(1'b1, 32'hA3, 1'b0, 1'b0);
    check("preflush.count", W'(bus.SC_RegIRQ_Count), 32'd2);
    step(1'b1, 32'hBB, 1'b1, 1'b1);
    check_all("flush");
    check("flush.count", W'(bus.SC_RegIRQ_Count), 32'd0);
    check("flush.ir",    bus.SC_RegIRQ_DataBUS_Out, 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_all("flush.absent");

    // Simultaneous push+next on empty (no bypass) and on full (push dropped)
    step(1'b1, 32'hC0, 1'b1, 1'b0);
    check_all("empty.pushnext");
    for (int i = 1; i < 4; i++) step(1'b1, 32'hC0 + W'(i), 1'b0, 1'b0);
    step(1'b1, 32'hCF, 1'b1, 1'b0);
    check_all("full.pushnext");

    // 6: asynchronous reset mid-cycle on a full queue
    step(1'b1, 32'hD0, 1'b0, 1'b0);
    check("async.prefull", W'(bus.SC_RegIRQ_Full), 32'd1);
    #5 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async");
    #1 rst_n = 1'b1;

    // Wrap: rotate pointers past DEPTH with push/next pairs
    step(1'b1, 32'hE0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'hF0 + W'(i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check_all("wrap");
      check("wrap.order", bus.SC_RegIRQ_DataBUS_Out, 32'hF0 + W'(i));
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic w, n, f;
      w = ($urandom_range(0, 99) < 60);
      n = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 4);
      step(w, $urandom, n, f);
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
